// File: rtl/tree_rr_arbiter.sv
// Round-robin arbiter built as a binary decision tree.
// Each tree node carries two candidates: the first requester at or above the
// round-robin pointer ("masked") and the first requester overall ("any").
// The root prefers the masked candidate. This yields a rotating scan starting
// at rr_q. An optional lock holds a stalled decision until its handshake.
module tree_rr_arbiter #(
    parameter int unsigned NumIn     = 5,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LockIn    = 1,
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic [NumIn-1:0]                    req_i,
    output logic [NumIn-1:0]                    gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
    output logic                                req_o,
    input  logic                                gnt_i,
    output logic [DataWidth-1:0]                data_o,
    output logic [IdxWidth-1:0]                 idx_o
);

    if (NumIn == 1) begin : gen_passthrough
        // A single requester needs no arbitration and holds no state.
        assign req_o  = req_i[0];
        assign gnt_o  = gnt_i;
        assign data_o = req_i[0] ? data_i[0] : '0;
        assign idx_o  = '0;
    end else begin : gen_tree
        localparam int unsigned Depth     = $clog2(NumIn);
        localparam int unsigned NumLeaves = 1 << Depth;
        localparam int unsigned NumNodes  = 2 * NumLeaves - 1;

        // Heap-ordered tree: node n has children 2n+1 and 2n+2, root is 0.
        logic [NumNodes-1:0] node_mv;
        logic [NumNodes-1:0] node_av;
        logic [IdxWidth-1:0] node_midx [NumNodes];
        logic [IdxWidth-1:0] node_aidx [NumNodes];

        logic [IdxWidth-1:0] rr_reg, rr_next;
        logic                lock_reg, lock_next;
        logic [IdxWidth-1:0] lock_idx_reg, lock_idx_next;

        logic                lock_hit;
        logic [IdxWidth-1:0] win_idx;
        logic                handshake;

        for (genvar gi = 0; gi <= Depth; gi++) begin : gen_level
            for (genvar gj = 0; gj < (1 << gi); gj++) begin : gen_node
                localparam int unsigned Node = (1 << gi) - 1 + gj;
                if (gi == Depth) begin : gen_leaf
                    if (gj < NumIn) begin : gen_live
                        localparam logic [IdxWidth-1:0] LeafIdx = IdxWidth'(gj);
                        assign node_av[Node]   = req_i[gj];
                        assign node_mv[Node]   = req_i[gj] & (LeafIdx >= rr_reg);
                        assign node_midx[Node] = LeafIdx;
                        assign node_aidx[Node] = LeafIdx;
                    end else begin : gen_pad
                        // Leaves past the last requester never request.
                        assign node_av[Node]   = 1'b0;
                        assign node_mv[Node]   = 1'b0;
                        assign node_midx[Node] = '0;
                        assign node_aidx[Node] = '0;
                    end
                end else begin : gen_inner
                    localparam int unsigned Left  = 2 * Node + 1;
                    localparam int unsigned Right = 2 * Node + 2;
                    // Lower index wins within each candidate class.
                    assign node_mv[Node]   = node_mv[Left] | node_mv[Right];
                    assign node_av[Node]   = node_av[Left] | node_av[Right];
                    assign node_midx[Node] = node_mv[Left] ? node_midx[Left] : node_midx[Right];
                    assign node_aidx[Node] = node_av[Left] ? node_aidx[Left] : node_aidx[Right];
                end
            end
        end

        // A lock only holds while its requester is still asking; otherwise
        // the tree result takes over immediately.
        assign lock_hit  = (LockIn != 0) && lock_reg && req_i[lock_idx_reg];
        assign win_idx   = lock_hit ? lock_idx_reg
                         : (node_mv[0] ? node_midx[0] : node_aidx[0]);
        assign req_o     = node_av[0];
        assign handshake = req_o & gnt_i;

        // Output steering: grant, payload and index of the winner.
        always_comb begin
            gnt_o  = '0;
            data_o = '0;
            idx_o  = '0;
            if (req_o) begin
                idx_o = win_idx;
                for (int i = 0; i < NumIn; i++) begin
                    if (win_idx == IdxWidth'(i)) begin
                        data_o   = data_i[i];
                        gnt_o[i] = gnt_i;
                    end
                end
            end
        end

        // Next pointer and lock; flush overrides any handshake update.
        always_comb begin
            rr_next       = rr_reg;
            lock_next     = 1'b0;
            lock_idx_next = lock_idx_reg;
            if (handshake) begin
                rr_next = (win_idx == IdxWidth'(NumIn - 1)) ? '0
                                                            : win_idx + IdxWidth'(1);
            end else if ((LockIn != 0) && req_o) begin
                lock_next     = 1'b1;
                lock_idx_next = win_idx;
            end
            if (flush_i) begin
                rr_next       = '0;
                lock_next     = 1'b0;
                lock_idx_next = '0;
            end
        end

        // State register with asynchronous active-low reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_reg       <= '0;
                lock_reg     <= 1'b0;
                lock_idx_reg <= '0;
            end else begin
                rr_reg       <= rr_next;
                lock_reg     <= lock_next;
                lock_idx_reg <= lock_idx_next;
            end
        end

`ifndef SYNTHESIS
        // A locked requester must keep requesting until it is served.
        if (LockIn != 0) begin : gen_lock_check
            locked_req_held : assert property (
                @(posedge clk_i) disable iff (!rst_ni)
                lock_reg |-> req_i[lock_idx_reg]
            );
        end
`endif
    end

endmodule

// File: tb/tb_tree_rr_arbiter.sv
// Directed plus constrained-random bench for tree_rr_arbiter (NumIn=5 and
// NumIn=1 instances side by side), with a scoreboard queue of expectations.
module tb_tree_rr_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [4:0]        req;
    logic [4:0]        gnt_o;
    logic              gnt;
    logic [4:0][31:0]  data;
    logic              req_o;
    logic [31:0]       data_o;
    logic [2:0]        idx_o;

    logic [0:0]        req1;
    logic [0:0]        gnt_o1;
    logic [0:0][31:0]  data1;
    logic              req_o1;
    logic [31:0]       data_o1;
    logic [0:0]        idx_o1;

    int checks = 0;
    int errors = 0;

    // Reference state: round-robin pointer and lock.
    int rr_m      = 0;
    int lock_m    = 0;
    int lockidx_m = 0;

    typedef struct {
        logic [4:0]  gnt;
        logic        req;
        logic [31:0] data;
        logic [2:0]  idx;
        logic        req1;
        logic        gnt1;
        logic [31:0] data1;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    tree_rr_arbiter #(.NumIn(5), .DataWidth(32), .LockIn(1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .req_i  (req),
        .gnt_o  (gnt_o),
        .data_i (data),
        .req_o  (req_o),
        .gnt_i  (gnt),
        .data_o (data_o),
        .idx_o  (idx_o)
    );

    tree_rr_arbiter #(.NumIn(1), .DataWidth(32), .LockIn(1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .req_i  (req1),
        .gnt_o  (gnt_o1),
        .data_i (data1),
        .req_o  (req_o1),
        .gnt_i  (gnt),
        .data_o (data_o1),
        .idx_o  (idx_o1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rotating scan from rr_m, honouring a held lock.
    function automatic int model_winner(input logic [4:0] r);
        int j;
        if (lock_m != 0 && r[lockidx_m]) return lockidx_m;
        for (int k = 0; k < 5; k++) begin
            j = (rr_m + k) % 5;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // One cycle: drive, queue expectation, compare at negedge, advance model.
    // exp_idx >= 0 forces a directed winner; -2 asks the model.
    task automatic step(input logic [4:0] r, input logic g, input logic f, input int exp_idx);
        exp_t e;
        exp_t got;
        int   w;
        req   = r;
        gnt   = g;
        flush = f;
        for (int i = 0; i < 5; i++) data[i] = $urandom;
        req1     = r[0:0];
        data1[0] = $urandom;
        w = (exp_idx == -2) ? model_winner(r) : exp_idx;
        e.req   = (r != 5'b0);
        e.idx   = (w < 0) ? 3'd0 : w[2:0];
        e.gnt   = (w >= 0 && g) ? (5'b00001 << w) : 5'b0;
        e.data  = (w >= 0) ? data[w] : 32'd0;
        e.req1  = r[0];
        e.gnt1  = g;
        e.data1 = r[0] ? data1[0] : 32'd0;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        $display("step req=%b gnt=%b flush=%b -> idx=%0d gnt_o=%b (exp idx=%0d gnt=%b)",
                 r, g, f, idx_o, gnt_o, got.idx, got.gnt);
        chk("idx",   32'(idx_o),   32'(got.idx));
        chk("gnt",   32'(gnt_o),   32'(got.gnt));
        chk("req",   32'(req_o),   32'(got.req));
        chk("data",  data_o,       got.data);
        chk("req1",  32'(req_o1),  32'(got.req1));
        chk("gnt1",  32'(gnt_o1),  32'(got.gnt1));
        chk("data1", data_o1,      got.data1);
        chk("idx1",  32'(idx_o1),  32'd0);
        if (f) begin
            rr_m   = 0;
            lock_m = 0;
        end else if (w >= 0 && g) begin
            rr_m   = (w + 1) % 5;
            lock_m = 0;
        end else if (w >= 0) begin
            lock_m    = 1;
            lockidx_m = w;
        end else begin
            lock_m = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        req1  = '0;
        gnt   = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 5; i++) data[i] = $urandom;
        data1[0] = $urandom;
        rr_m   = 0;
        lock_m = 0;
        #2;
        $display("reset: req_o=%b gnt_o=%b data_o=%0h idx_o=%0d", req_o, gnt_o, data_o, idx_o);
        chk("rst_req",   32'(req_o),   32'd0);
        chk("rst_gnt",   32'(gnt_o),   32'd0);
        chk("rst_data",  data_o,       32'd0);
        chk("rst_idx",   32'(idx_o),   32'd0);
        chk("rst_req1",  32'(req_o1),  32'd0);
        chk("rst_data1", data_o1,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] r;
        logic       g;
        logic       f;

        do_reset();

        // First pick and pointer advance past the winner.
        step(5'b10100, 1'b1, 1'b0, 2);
        step(5'b10100, 1'b1, 1'b0, 4);

        // Full rotation with wrap from NumIn-1 back to 0.
        do_reset();
        for (int k = 0; k < 6; k++) step(5'b11111, 1'b1, 1'b0, k % 5);

        // Lock holds through a stall, then the pointer moves on.
        do_reset();
        for (int k = 0; k < 3; k++) step(5'b00011, 1'b0, 1'b0, 0);
        step(5'b00011, 1'b1, 1'b0, 0);
        step(5'b00011, 1'b1, 1'b0, 1);
        step(5'b00010, 1'b0, 1'b0, 1);
        step(5'b00011, 1'b0, 1'b0, 1);
        step(5'b00011, 1'b1, 1'b0, 1);
        step(5'b00011, 1'b1, 1'b0, 0);

        // Flush beats a simultaneous handshake, and clears a held lock.
        do_reset();
        step(5'b01000, 1'b1, 1'b1, 3);
        step(5'b11111, 1'b1, 1'b0, 0);
        step(5'b00100, 1'b0, 1'b0, 2);
        step(5'b00110, 1'b0, 1'b1, 2);
        step(5'b00110, 1'b0, 1'b0, 1);
        step(5'b00110, 1'b1, 1'b0, 1);

        // Asynchronous reset while locked on index 2.
        do_reset();
        step(5'b00001, 1'b1, 1'b0, 0);
        step(5'b00100, 1'b0, 1'b0, 2);
        step(5'b00101, 1'b0, 1'b0, 2);
        req = 5'b00101;
        gnt = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        $display("midlock reset: idx_o=%0d gnt_o=%b", idx_o, gnt_o);
        chk("midlock_gnt", 32'(gnt_o), 32'd0);
        chk("midlock_idx", 32'(idx_o), 32'd0);
        rr_m   = 0;
        lock_m = 0;
        req    = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(5'b00101, 1'b1, 1'b0, 0);
        step(5'b00101, 1'b1, 1'b0, 2);

        // Random traffic; a locked requester keeps requesting.
        for (int k = 0; k < 40; k++) begin
            r = 5'($urandom);
            if (lock_m != 0) r[lockidx_m] = 1'b1;
            g = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 9) == 0);
            step(r, g, f, -2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
